// File: rtl/sar_pkg.sv
// Shared constants and state encoding for the SAR conversion sequencer.
//   ADC_BITS        : resolution of the SAR macro
//   SAR_CYC_PER_BIT : nominal SAR clocks spent per bit decision
//   ST_*            : 3-bit sequencer state codes, wrapped by state_t
package sar_pkg;

    localparam int ADC_BITS        = 6;
    localparam int SAR_CYC_PER_BIT = 6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_ABORT   = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RUN     = ST_RUN,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD,
        ABORT   = ST_ABORT
    } state_t;

endpackage

// File: rtl/sar_result_fifo.sv
// Synchronous result FIFO between the sequencer and the host.
//   i_clk, i_rst : clock, synchronous active-high reset (pointers/count only)
//   i_push       : write request (i_data)
//   i_pop        : host pop request; ignored while empty
//   o_data       : head entry, forced to 0 while empty
//   o_valid      : FIFO not empty
//   o_level      : entry count, 0..DEPTH
//   o_drop       : pulse when a push is refused because the FIFO stays full
module sar_result_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_drop  = i_push & w_full & ~w_pop;

    assign o_valid = ~w_empty;
    assign o_level = r_count;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Conversion controller for the 6-bit SAR ADC macro.
// Releases the SAR from reset for single-shot or continuous runs, detects the
// EOC rising edge, captures DIGITAL_OUT into a result FIFO, and aborts any
// conversion that exceeds TIMEOUT_CYC clocks.
// Optional build macro SAR_AVG_EN: average 2^AVG_LOG2 captures per pushed result.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   START, CONT, STOP : run control (CONT sampled with START)
//   SAR_EOC, SAR_DOUT : end-of-conversion and result from the SAR
//   SAR_XRST          : active-low SAR reset (registered)
//   RES_DATA/VALID/READY, FIFO_LEVEL : result FIFO host interface
//   BUSY, OVERFLOW, TIMEOUT_ERR      : status (last two sticky until START)
module sar_conv_sequencer #(
    parameter int ADC_BITS    = sar_pkg::ADC_BITS,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
`ifdef SAR_AVG_EN
   ,parameter int AVG_LOG2    = 2
`endif
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          CONT,
    input  logic                          STOP,
    input  logic                          SAR_EOC,
    input  logic [ADC_BITS-1:0]           SAR_DOUT,
    output logic                          SAR_XRST,
    output logic [ADC_BITS-1:0]           RES_DATA,
    output logic                          RES_VALID,
    input  logic                          RES_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          BUSY,
    output logic                          OVERFLOW,
    output logic                          TIMEOUT_ERR
);

    import sar_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode;
    logic               r_stop_pend;
    logic               r_eoc_q;
    logic               r_xrst;
    logic               r_overflow;
    logic               r_timeout;
    logic [WD_W-1:0]    r_wdog;

    logic               w_eoc_rise;
    logic               w_stop_eff;
    logic               w_win_done;
    logic               w_push;
    logic               w_drop;
    logic [ADC_BITS-1:0] w_push_data;

    assign w_eoc_rise = SAR_EOC & ~r_eoc_q;
    // A STOP arriving in the CAPTURE cycle itself still ends the run there.
    assign w_stop_eff = r_stop_pend | STOP;

`ifdef SAR_AVG_EN
    localparam int ACC_W = ADC_BITS + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_avg_cnt;
    logic [ACC_W-1:0]    w_acc_sum;

    assign w_acc_sum   = r_acc + ACC_W'(SAR_DOUT);
    assign w_win_done  = &r_avg_cnt;
    assign w_push_data = ADC_BITS'(w_acc_sum >> AVG_LOG2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
        end else if ((r_state == IDLE && START) || r_state == ABORT) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
        end else if (r_state == CAPTURE) begin
            r_acc     <= w_win_done ? '0 : w_acc_sum;
            r_avg_cnt <= r_avg_cnt + AVG_LOG2'(1);
        end
    end
`else
    assign w_win_done  = 1'b1;
    assign w_push_data = SAR_DOUT;
`endif

    assign w_push = (r_state == CAPTURE) & w_win_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (START) w_state_nxt = RUN;
            RUN: begin
                if (w_eoc_rise)
                    w_state_nxt = CAPTURE;
                else if (r_wdog == WD_W'(TIMEOUT_CYC - 1))
                    w_state_nxt = ABORT;
            end
            // A run only ends on the capture that completes an averaging window.
            CAPTURE: w_state_nxt = ((~r_mode | w_stop_eff) & w_win_done) ? HOLD : RUN;
            HOLD:    w_state_nxt = IDLE;
            ABORT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_eoc_q     <= 1'b0;
            r_xrst      <= 1'b0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // SAR reset output is the registered decode of the current state.
            r_xrst  <= (r_state == RUN) || (r_state == CAPTURE);
            // Forcing the EOC copy low while the SAR is held stops a stale EOC faking an edge.
            r_eoc_q <= r_xrst ? SAR_EOC : 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_mode      <= CONT;
                        r_overflow  <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_wdog      <= '0;
                        r_stop_pend <= 1'b0;
                    end
                end
                RUN: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (STOP) r_stop_pend <= 1'b1;
                end
                CAPTURE: begin
                    r_wdog <= '0;
                    if (STOP) r_stop_pend <= 1'b1;
                end
                HOLD:  r_stop_pend <= 1'b0;
                ABORT: begin
                    r_timeout   <= 1'b1;
                    r_stop_pend <= 1'b0;
                end
                default: ;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    sar_result_fifo #(
        .DATA_W (ADC_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (RES_READY),
        .o_data  (RES_DATA),
        .o_valid (RES_VALID),
        .o_level (FIFO_LEVEL),
        .o_drop  (w_drop)
    );

    assign SAR_XRST    = r_xrst;
    assign BUSY        = (r_state != IDLE);
    assign OVERFLOW    = r_overflow;
    assign TIMEOUT_ERR = r_timeout;

endmodule
